// File: rtl/z_core_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : z_core_reg_file
//  Brief    : RV32I integer register file, 2 combinational reads, 1 write,
//             x0 hardwired to zero, asynchronous active-high reset.
//             Optional macro Z_CORE_REG_FILE_BYPASS_EN adds write-through bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module z_core_reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] rd_in,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   output logic [DATA_WIDTH-1:0] rs1_out,
   output logic [DATA_WIDTH-1:0] rs2_out
);

   localparam int c_DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs_q [c_DEPTH];
   logic [DATA_WIDTH-1:0] r_regs_d [c_DEPTH];
   logic                  w_wr_commit;
   logic [c_DEPTH-1:0]    w_wr_sel;

   // An X on write_enable evaluates false in the if() below, so no write happens.
   assign w_wr_commit = (write_enable == 1'b1) && !reset && (rd != '0);

   generate
      for (genvar g = 0; g < c_DEPTH; g++) begin : g_dec
         if (g == 0) begin : g_x0
            assign w_wr_sel[g] = 1'b0;
         end else begin : g_xn
            assign w_wr_sel[g] = w_wr_commit && (rd == ADDR_WIDTH'(g));
         end
      end
   endgenerate

   always_comb begin
      for (int i = 0; i < c_DEPTH; i++) begin
         r_regs_d[i] = r_regs_q[i];
         if (w_wr_sel[i]) begin
            r_regs_d[i] = rd_in;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs_q[i] <= r_regs_d[i];
         end
      end
   end

`ifdef Z_CORE_REG_FILE_BYPASS_EN
   // Forward in-flight write data to a reader of the same index before the edge.
   always_comb begin
      rs1_out = '0;
      if (rs1 != '0) begin
         rs1_out = (w_wr_commit && (rs1 == rd)) ? rd_in : r_regs_q[rs1];
      end
   end

   always_comb begin
      rs2_out = '0;
      if (rs2 != '0) begin
         rs2_out = (w_wr_commit && (rs2 == rd)) ? rd_in : r_regs_q[rs2];
      end
   end
`else
   always_comb begin
      rs1_out = '0;
      if (rs1 != '0) begin
         rs1_out = r_regs_q[rs1];
      end
   end

   always_comb begin
      rs2_out = '0;
      if (rs2 != '0) begin
         rs2_out = r_regs_q[rs2];
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_z_core_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_z_core_reg_file
//  Brief    : Scoreboard bench for z_core_reg_file against an array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_z_core_reg_file;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          write_enable;
   logic [AW-1:0] rd;
   logic [DW-1:0] rd_in;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [DW-1:0] rs1_out;
   logic [DW-1:0] rs2_out;

   always #5 clk = ~clk;

   z_core_reg_file #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .rd           (rd),
      .rd_in        (rd_in),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_out      (rs1_out),
      .rs2_out      (rs2_out)
   );

   typedef struct {
      string         name;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } exp_t;

   exp_t          sb_q[$];
   event          ev_sample;
   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] model [DEPTH];

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
      if (reset || idx == 0) return '0;
`ifdef Z_CORE_REG_FILE_BYPASS_EN
      if (write_enable === 1'b1 && rd != 0 && idx == rd) return rd_in;
`endif
      return model[idx];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   task automatic push_expect(input string name);
      exp_t e;
      e.name = name;
      e.e1   = model_read(rs1);
      e.e2   = model_read(rs2);
      sb_q.push_back(e);
      -> ev_sample;
   endtask

   // One cycle: drive between edges, queue expected reads, then commit model on the edge.
   task automatic drive(input string name, input logic r, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2);
      @(negedge clk);
      reset = r; write_enable = we; rd = a; rd_in = d; rs1 = s1; rs2 = s2;
      if (r) clear_model();
      push_expect(name);
      @(posedge clk);
      if (!r && we && a != 0) model[a] = d;
   endtask

   // Reset asserted between edges while a write is pending.
   task automatic async_reset_check();
      @(negedge clk);
      reset = 1'b0; write_enable = 1'b1; rd = 5'd3; rd_in = 32'd123;
      rs1 = 5'd3; rs2 = 5'd5;
      #1;
      reset = 1'b1;
      clear_model();
      push_expect("async_rst");
      @(posedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(ev_sample);
         #2;
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: sample event with no expected entry (queue size=0, required>=1)");
         end else begin
            e = sb_q.pop_front();
            checks++;
            if (rs1_out !== e.e1) begin
               failures++;
               $display("FAIL %s rs1=%0d rs1_out actual=%h expected=%h", e.name, rs1, rs1_out, e.e1);
            end
            checks++;
            if (rs2_out !== e.e2) begin
               failures++;
               $display("FAIL %s rs2=%0d rs2_out actual=%h expected=%h", e.name, rs2, rs2_out, e.e2);
            end
         end
      end
   end

   initial begin : stimulus
      logic [AW-1:0] a, s1, s2;
      logic          we, r;
      reset = 1'b1; write_enable = 1'b0; rd = '0; rd_in = '0; rs1 = '0; rs2 = '0;
      clear_model();

      drive("rst_x0",      1'b1, 1'b0, 5'd0,  32'd0,  5'd0, 5'd0);
      drive("rst_5_31",    1'b1, 1'b0, 5'd0,  32'd0,  5'd5, 5'd31);
      drive("wr_x5",       1'b0, 1'b1, 5'd5,  32'd15, 5'd0, 5'd0);
      drive("wr_x8",       1'b0, 1'b1, 5'd8,  32'd25, 5'd5, 5'd8);
      drive("rd_5_8",      1'b0, 1'b0, 5'd0,  32'd0,  5'd5, 5'd8);
      drive("rd_8_5",      1'b0, 1'b0, 5'd0,  32'd0,  5'd8, 5'd5);
      drive("we_off",      1'b0, 1'b0, 5'd10, 32'd30, 5'd0, 5'd10);
      drive("we_off_rd",   1'b0, 1'b0, 5'd0,  32'd0,  5'd0, 5'd10);
      drive("x0_wr",       1'b0, 1'b1, 5'd0,  32'd40, 5'd0, 5'd10);
      drive("x0_rd",       1'b0, 1'b0, 5'd0,  32'd0,  5'd0, 5'd10);
      drive("wr_x3",       1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 5'd0, 5'd0);
      drive("rd_x3",       1'b0, 1'b0, 5'd0,  32'd0,  5'd3, 5'd3);
      async_reset_check();
      drive("rst_wr",      1'b1, 1'b1, 5'd3,  32'd77, 5'd3, 5'd0);
      drive("post_rst",    1'b0, 1'b0, 5'd0,  32'd0,  5'd3, 5'd5);
      drive("first_wr",    1'b0, 1'b1, 5'd4,  32'd44, 5'd4, 5'd0);
      drive("first_rd",    1'b0, 1'b0, 5'd0,  32'd0,  5'd4, 5'd4);
      drive("same_pre",    1'b0, 1'b1, 5'd7,  32'd9,  5'd7, 5'd0);
      drive("same_post",   1'b0, 1'b0, 5'd0,  32'd0,  5'd7, 5'd7);
      drive("same_x0_byp", 1'b0, 1'b1, 5'd0,  32'd66, 5'd0, 5'd0);

      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 49) == 0);
         we = $urandom_range(0, 1);
         a  = AW'($urandom_range(0, DEPTH-1));
         s1 = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, DEPTH-1));
         s2 = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, DEPTH-1));
         drive("random", r, we, a, $urandom, s1, s2);
      end

      @(negedge clk);
      write_enable = 1'b0;
      #4;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: entries left actual=%0d required=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
